// File: rtl/rename_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rename_stage                                                    |
// | Purpose  : RAT + circular free-list register renamer, 1 uop/cycle, with a  |
// |            single-entry valid/ready output register toward dispatch.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rename_stage #(
  parameter int XLEN  = 32,
  parameter int PREGS = 64,
  parameter int PW    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uop_valid_in,
  output logic            rename_ready_out,
  input  logic [6:0]      uop_in,
  input  logic            eoi_in,
  input  logic            use_imm_in,
  input  logic            except_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      src1_arch_in,
  input  logic [4:0]      src2_arch_in,
  input  logic [4:0]      dest_arch_in,
  input  logic            free_valid_in,
  input  logic [PW-1:0]   free_preg_in,
  input  logic            dispatch_ready_in,
  output logic            valid_out,
  output logic [6:0]      uop_out,
  output logic            eoi_out,
  output logic            use_imm_out,
  output logic            except_out,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] pc_out,
  output logic [PW-1:0]   src1_phys_out,
  output logic [PW-1:0]   src2_phys_out,
  output logic [PW-1:0]   dest_phys_out,
  output logic [PW-1:0]   old_dest_phys_out
);

  localparam int c_FL   = PREGS - 32;
  localparam int c_PTRW = $clog2(c_FL);
  localparam int c_CNTW = $clog2(c_FL + 1);

  logic [PW-1:0]     r_rat [32];
  logic [PW-1:0]     r_fl  [c_FL];
  logic [c_PTRW-1:0] r_head;
  logic [c_PTRW-1:0] r_tail;
  logic [c_CNTW-1:0] r_count;

  logic              r_valid;
  logic [6:0]        r_uop;
  logic              r_eoi;
  logic              r_use_imm;
  logic              r_except;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic [PW-1:0]     r_src1;
  logic [PW-1:0]     r_src2;
  logic [PW-1:0]     r_dest;
  logic [PW-1:0]     r_old;

  logic              w_ready;
  logic              w_accept;
  logic              w_alloc;
  logic              w_push;
  logic [c_PTRW-1:0] w_head_nxt;
  logic [c_PTRW-1:0] w_tail_nxt;

  assign w_ready  = (!r_valid || dispatch_ready_in) && (r_count != '0);
  assign w_accept = uop_valid_in && w_ready;
  // x0 and excepting uops never consume a physical register
  assign w_alloc  = w_accept && (dest_arch_in != 5'd0) && !except_in;
  assign w_push   = free_valid_in && (free_preg_in != '0) &&
                    (r_count != c_CNTW'(c_FL));

  assign w_head_nxt = (r_head == c_PTRW'(c_FL - 1)) ? '0 : r_head + c_PTRW'(1);
  assign w_tail_nxt = (r_tail == c_PTRW'(c_FL - 1)) ? '0 : r_tail + c_PTRW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rat[i] <= PW'(i);
      for (int i = 0; i < c_FL; i++) r_fl[i] <= PW'(32 + i);
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= c_CNTW'(c_FL);
      r_valid   <= 1'b0;
      r_uop     <= '0;
      r_eoi     <= 1'b0;
      r_use_imm <= 1'b0;
      r_except  <= 1'b0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_dest    <= '0;
      r_old     <= '0;
    end else begin
      if (w_alloc) begin
        r_rat[dest_arch_in] <= r_fl[r_head];
        r_head              <= w_head_nxt;
      end
      if (w_push) begin
        r_fl[r_tail] <= free_preg_in;
        r_tail       <= w_tail_nxt;
      end
      if (w_alloc && !w_push) begin
        r_count <= r_count - c_CNTW'(1);
      end else if (w_push && !w_alloc) begin
        r_count <= r_count + c_CNTW'(1);
      end

      if (w_accept) begin
        r_valid   <= 1'b1;
        r_uop     <= uop_in;
        r_eoi     <= eoi_in;
        r_use_imm <= use_imm_in;
        r_except  <= except_in;
        r_imm     <= imm_in;
        r_pc      <= pc_in;
        // sources see the pre-update RAT, so src==dest gets the old mapping
        r_src1    <= r_rat[src1_arch_in];
        r_src2    <= r_rat[src2_arch_in];
        r_dest    <= w_alloc ? r_fl[r_head] : '0;
        r_old     <= w_alloc ? r_rat[dest_arch_in] : '0;
      end else if (dispatch_ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rename_ready_out  = w_ready;
  assign valid_out         = r_valid;
  assign uop_out           = r_uop;
  assign eoi_out           = r_eoi;
  assign use_imm_out       = r_use_imm;
  assign except_out        = r_except;
  assign imm_out           = r_imm;
  assign pc_out            = r_pc;
  assign src1_phys_out     = r_src1;
  assign src2_phys_out     = r_src2;
  assign dest_phys_out     = r_dest;
  assign old_dest_phys_out = r_old;

endmodule
`default_nettype wire
